// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared types and constants for the AHB-Lite UART transmitter slave.
// Register offsets, slave base decode, serializer states, bus request bundle.
package mfp_ahb_uart_tx_pkg;

    // Base address of this slave in the mfp_ahb_withloader map and the
    // address bits the decoder compares to select it.
    localparam logic [31:0] UART_TX_BASE_ADDR = 32'h1f80_0040;
    localparam logic [31:0] UART_TX_BASE_MASK = 32'hffff_fff0;

    // Byte offsets within the slave.
    localparam logic [3:0] UART_TX_OFF_TXDATA  = 4'h0;
    localparam logic [3:0] UART_TX_OFF_STATUS  = 4'h4;
    localparam logic [3:0] UART_TX_OFF_BAUDDIV = 4'h8;

    // Register index as seen on HADDR[3:2].
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS bit positions.
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Address-phase capture, consumed in the following data phase.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [1:0] addr;
    } bus_req_t;

    // A bit period shorter than two clocks is not supported.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/mfp_ahb_uart_tx_if.sv
// AHB-Lite slave-side signal bundle for the UART transmitter.
// master: decoder/bus side drives HSEL..HWDATA; slave: drives HRDATA.
interface mfp_ahb_uart_tx_if;
    logic        HSEL;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA
    );
endinterface

// File: rtl/mfp_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, single clock.
// Ports: clk, rst (sync, active high), push/wdata, pop/rdata, full, empty, count.
module mfp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    // A simultaneous pop frees a slot, so a push to a full FIFO still lands.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite UART transmitter: TX FIFO fed by bus writes, 8N1 serializer.
// Ports: HCLK, SI_Reset (sync, active high), ahb (slave bundle), UART_TX, TX_IRQ.
module mfp_ahb_uart_tx
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic             HCLK,
    input  logic             SI_Reset,
    mfp_ahb_uart_tx_if.slave ahb,
    output logic             UART_TX,
    output logic             TX_IRQ
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus-side state
    bus_req_t    req_q, req_d;
    logic [15:0] baud_q, baud_d;
    logic        ovf_q, ovf_d;

    // Serializer state
    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic          wr_en, push, pop;
    logic          full, empty, bit_end, busy;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] count;
    logic [7:0]    count8;
    logic          unused_bits;

    assign unused_bits = ^{ahb.HWDATA[31:16], ahb.HADDR[1:0]};

    mfp_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (SI_Reset),
        .push  (push),
        .wdata (ahb.HWDATA[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign count8 = 8'(count);
    assign busy   = (state_q != ST_IDLE);

    // ---------------- bus register file ----------------

    always_comb begin
        req_d.valid = ahb.HSEL & ahb.HTRANS[1];
        req_d.write = ahb.HWRITE;
        req_d.addr  = ahb.HADDR[3:2];
    end

    assign wr_en = req_q.valid & req_q.write;
    assign push  = wr_en & (req_q.addr == REG_TXDATA);

    always_comb begin
        baud_d = baud_q;
        ovf_d  = ovf_q;
        if (wr_en && req_q.addr == REG_BAUDDIV)
            baud_d = clamp_div(ahb.HWDATA[15:0]);
        if (wr_en && req_q.addr == REG_STATUS && ahb.HWDATA[STAT_OVF])
            ovf_d = 1'b0;
        // Dropped byte: full and the serializer is not freeing a slot.
        if (push && full && !pop)
            ovf_d = 1'b1;
    end

    always_comb begin
        ahb.HRDATA = '0;
        if (req_q.valid && !req_q.write) begin
            unique case (req_q.addr)
                REG_STATUS: begin
                    ahb.HRDATA[15:8]       = count8;
                    ahb.HRDATA[STAT_OVF]   = ovf_q;
                    ahb.HRDATA[STAT_EMPTY] = empty;
                    ahb.HRDATA[STAT_FULL]  = full;
                    ahb.HRDATA[STAT_BUSY]  = busy;
                end
                REG_BAUDDIV: ahb.HRDATA[15:0] = baud_q;
                default:     ahb.HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            req_q  <= '0;
            baud_q <= DIV_DEFAULT;
            ovf_q  <= 1'b0;
        end else begin
            req_q  <= req_d;
            baud_q <= baud_d;
            ovf_q  <= ovf_d;
        end
    end

    // ---------------- serializer ----------------

    assign bit_end = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    div_d   = baud_q;
                    cnt_d   = baud_q - 16'd1;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = div_q - 16'd1;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = div_q - 16'd1;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Chain the next frame without an idle bit.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        div_d   = baud_q;
                        cnt_d   = baud_q - 16'd1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_DEFAULT;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign UART_TX = tx_q;
    assign TX_IRQ  = empty & ~busy;

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Testbench for mfp_ahb_uart_tx: directed scenarios plus random bus traffic,
// checked every cycle against a frame-level behavioural model.
module tb_mfp_ahb_uart_tx;
    localparam int DEPTH  = 16;
    localparam int DIVDEF = 434;

    logic HCLK = 1'b0;
    logic SI_Reset = 1'b1;
    logic UART_TX, TX_IRQ;

    mfp_ahb_uart_tx_if bus();

    mfp_ahb_uart_tx #(
        .FIFO_DEPTH  (DEPTH),
        .DIV_DEFAULT (16'(DIVDEF))
    ) dut (
        .HCLK     (HCLK),
        .SI_Reset (SI_Reset),
        .ahb      (bus),
        .UART_TX  (UART_TX),
        .TX_IRQ   (TX_IRQ)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of pending bytes; the frame on the line is (byte, divisor,
    // clocks elapsed). Line level follows from elapsed / divisor.
    byte unsigned mq[$];
    bit           m_act;
    int           m_pos;
    int           m_fdiv;
    logic [7:0]   m_fbyte;
    bit           m_ovf;
    int           m_div;
    bit           m_pv, m_pw;
    logic [1:0]   m_pa;
    bit           m_live = 1'b0;

    // Frame bit k: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic framebit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic exp_tx();
        if (!m_act) return 1'b1;
        return framebit(m_fbyte, m_pos / m_fdiv);
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        r = '0;
        if (m_pv && !m_pw) begin
            if (m_pa == 2'd1) begin
                r[0]    = m_act;
                r[1]    = (mq.size() == DEPTH);
                r[2]    = (mq.size() == 0);
                r[3]    = m_ovf;
                r[15:8] = 8'(mq.size());
            end else if (m_pa == 2'd2) begin
                r[15:0] = 16'(m_div);
            end
        end
        return r;
    endfunction

    always @(posedge HCLK) begin : model
        int pre;
        bit popped;
        int v;
        if (SI_Reset) begin
            mq.delete();
            m_act  = 1'b0;
            m_pos  = 0;
            m_fdiv = DIVDEF;
            m_ovf  = 1'b0;
            m_div  = DIVDEF;
            m_pv   = 1'b0;
            m_pw   = 1'b0;
            m_pa   = 2'd0;
            m_live = 1'b1;
        end else begin
            pre    = mq.size();
            popped = 1'b0;
            if (m_act && (m_pos + 1 < 10 * m_fdiv)) begin
                m_pos++;
            end else if (pre > 0) begin
                m_fbyte = mq.pop_front();
                m_fdiv  = m_div;
                m_pos   = 0;
                m_act   = 1'b1;
                popped  = 1'b1;
            end else begin
                m_act = 1'b0;
                m_pos = 0;
            end
            if (m_pv && m_pw) begin
                case (m_pa)
                    2'd0: begin
                        if (pre == DEPTH && !popped) m_ovf = 1'b1;
                        else mq.push_back(bus.HWDATA[7:0]);
                    end
                    2'd1: if (bus.HWDATA[3]) m_ovf = 1'b0;
                    2'd2: begin
                        v = int'(bus.HWDATA[15:0]);
                        m_div = (v < 2) ? 2 : v;
                    end
                    default: ;
                endcase
            end
            m_pv = bus.HSEL && bus.HTRANS[1];
            m_pw = bus.HWRITE;
            m_pa = bus.HADDR[3:2];
        end
    end

    always @(negedge HCLK) begin
        if (m_live) begin
            check("uart_tx", 32'(UART_TX), 32'(exp_tx()));
            check("tx_irq", 32'(TX_IRQ), 32'(mq.size() == 0 && !m_act));
            check("hrdata", bus.HRDATA, exp_rd());
        end
    end

    // ---------------- bus driver ----------------
    logic [31:0] pend = '0;

    task automatic drive(input bit sel, input logic [1:0] tr,
                         input logic [3:0] a, input bit w,
                         input logic [31:0] d);
        @(negedge HCLK);
        bus.HWDATA = pend;
        bus.HSEL   = sel;
        bus.HTRANS = tr;
        bus.HADDR  = a;
        bus.HWRITE = w;
        pend       = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        drive(1'b1, 2'b10, a, 1'b1, d);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        drive(1'b1, 2'b10, a, 1'b0, 32'h0);
        idle(1);
        d = bus.HRDATA;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (TX_IRQ !== 1'b1 && n < maxc) begin
            idle(1);
            n++;
        end
        check("wait_idle", 32'(TX_IRQ), 32'd1);
    endtask

    logic [31:0] r;
    logic [19:0] pat4 = 20'b1000_0111_1011_0100_0000;
    int          mism;

    initial begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = 4'h0;
        bus.HWRITE = 1'b0;
        bus.HWDATA = '0;
        repeat (3) @(negedge HCLK);
        SI_Reset = 1'b0;

        // 1: reset state
        idle(1);
        check("rst_tx", 32'(UART_TX), 32'd1);
        check("rst_irq", 32'(TX_IRQ), 32'd1);
        rd(4'h4, r);
        check("rst_status", r, 32'h4);
        rd(4'h8, r);
        check("rst_baud", r, 32'd434);

        // 2: single frame 0x55 at 4 clocks/bit
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h55);
        idle(1);
        idle(1);
        check("lat_t1_high", 32'(UART_TX), 32'd1);
        mism = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (UART_TX !== 1'((i / 4) % 2)) mism++;
            if (TX_IRQ !== 1'b0) mism++;
        end
        check("frame55_wave", 32'(mism), 32'd0);
        idle(1);
        check("frame55_end_tx", 32'(UART_TX), 32'd1);
        check("frame55_end_irq", 32'(TX_IRQ), 32'd1);

        // 3: overflow while serializer busy
        wr(4'h8, 32'd2);
        wr(4'h0, 32'hEE);
        for (int i = 0; i < 17; i++) wr(4'h0, 32'(i));
        rd(4'h4, r);
        check("ovf_status", r, 32'h100B);
        wr(4'h4, 32'h8);
        rd(4'h4, r);
        check("ovf_clear", r, 32'h1003);
        wait_idle(2000);

        // 4: back-to-back frames at 3 clocks/bit
        wr(4'h8, 32'd3);
        wr(4'h0, 32'hA0);
        wr(4'h0, 32'h0F);
        idle(1);
        mism = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if (UART_TX !== pat4[i / 3]) mism++;
        end
        check("b2b_wave", 32'(mism), 32'd0);
        idle(1);
        check("b2b_end_tx", 32'(UART_TX), 32'd1);
        check("b2b_end_irq", 32'(TX_IRQ), 32'd1);

        // 5: divisor clamp and mid-frame change
        wr(4'h8, 32'd0);
        rd(4'h8, r);
        check("baud_min", r, 32'd2);
        wr(4'h0, 32'h3C);
        wr(4'h0, 32'hC3);
        wr(4'h8, 32'd8);
        idle(1);
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) idle(1);
            if (i < 20) begin
                if (UART_TX !== framebit(8'h3C, i / 2)) mism++;
            end else begin
                if (UART_TX !== framebit(8'hC3, (i - 20) / 8)) mism++;
            end
        end
        check("divchg_wave", 32'(mism), 32'd0);
        idle(1);
        check("divchg_end_tx", 32'(UART_TX), 32'd1);
        wait_idle(200);

        // 6: reset during data bit 4
        wr(4'h8, 32'd4);
        idle(1);
        wr(4'h0, 32'h0F);
        wr(4'h0, 32'h22);
        wr(4'h0, 32'h33);
        idle(1);
        idle(21);
        check("pre_rst_bit4", 32'(UART_TX), 32'd0);
        SI_Reset = 1'b1;
        idle(1);
        SI_Reset = 1'b0;
        check("rst_mid_tx", 32'(UART_TX), 32'd1);
        rd(4'h4, r);
        check("rst_mid_status", r, 32'h4);
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (UART_TX !== 1'b1) mism++;
        end
        check("rst_no_frames", 32'(mism), 32'd0);
        wr(4'h8, 32'd3);
        idle(1);

        // random bus traffic at decreasing density
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int n = 0; n < 700; n++) begin
                int          op;
                logic [3:0]  a;
                logic [31:0] d;
                op = $urandom_range(0, 15 + 10 * rnd);
                a  = 4'($urandom_range(0, 15));
                d  = $urandom;
                case (op)
                    0, 1, 2: drive(1'b1, 2'b10, {2'd0, a[1:0]}, 1'b1, d);
                    3: drive(1'b1, 2'b11, {2'd2, a[1:0]}, 1'b1,
                             32'($urandom_range(0, 5)));
                    4: drive(1'b1, 2'b10, {2'd1, a[1:0]}, 1'b1, d);
                    5, 6: drive(1'b1, 2'b10, {2'd1, a[1:0]}, 1'b0, d);
                    7: drive(1'b1, 2'b11, {2'd2, a[1:0]}, 1'b0, d);
                    8: drive(1'b1, 2'b10, {2'd3, a[1:0]}, d[31], d);
                    9: drive(1'b1, 2'b10, {2'd0, a[1:0]}, 1'b0, d);
                    10: drive(1'b0, 2'b10, a, 1'b1, d);
                    11: drive(1'b1, 2'($urandom_range(0, 1)), a, 1'b1, d);
                    12: begin
                        if ($urandom_range(0, 30) == 0) begin
                            idle(1);
                            SI_Reset = 1'b1;
                            idle(1);
                            SI_Reset = 1'b0;
                            wr(4'h8, 32'd3);
                        end else begin
                            idle(1);
                        end
                    end
                    default: idle(1);
                endcase
            end
            idle(2);
            wait_idle(3000);
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
